data_sram_ctrl: RTL and testbench
=================================

// Module: data_sram_ctrl
// PURPOSE
//  Bridges the pipeline's single-cycle data-memory port (MEM stage) to an external
//  word-wide asynchronous SRAM with a configurable number of wait states.
//  Latches each request, sequences CE/OE/WE/BE strobes, and holds the pipeline via
//  stallreq_o until the access completes. Read data returns registered to the MEM stage.
// PARAMETERS
//  ADDR_W       20  SRAM word-address width; mem_addr_i[ADDR_W+1:2] used, upper bits ignored (wrap)
//  WAIT_CYCLES  2   strobe-active cycles per access before sample/hold cycle (legal 1..15)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  mem_ce_i      in   1       data request valid from MEM stage
//  mem_we_i      in   1       1=write, 0=read
//  mem_sel_i     in   4       byte-lane select, bit0 = bits[7:0]
//  mem_addr_i    in   32      byte address; [1:0] ignored
//  mem_data_i    in   32      write data
//  pipe_hold_i   in   1       pipeline held by another stall source this cycle
//  mem_data_o    out  32      read data, valid in DONE only, else 0
//  stallreq_o    out  1       stall request to pipeline control
//  sram_addr_o   out  ADDR_W  SRAM word address
//  sram_data_o   out  32      SRAM write data
//  sram_data_i   in   32      SRAM read data
//  sram_data_oe_o out 1       1 = drive sram_data_o onto the bus
//  sram_ce_n_o   out  1       chip enable, active-low
//  sram_oe_n_o   out  1       output enable, active-low
//  sram_we_n_o   out  1       write enable, active-low
//  sram_be_n_o   out  4       byte enables, active-low
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, cnt=0, rdata_q=0; while rst=1 stallreq_o=0, mem_data_o=0.
//   SRAM outputs after reset: ce_n/oe_n/we_n=1, be_n=4'hF, data_oe=0, addr=0, data=0.
//   Reset mid-access aborts. Strobes are inactive from the next edge. No partial-write recovery.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: stallreq_o = mem_ce_i (combinational, same cycle). On mem_ce_i=1, latch we/sel/addr/data
//   into request regs and set cnt=0. Next state is ACCESS.
//  ACCESS: WAIT_CYCLES+1 cycles (cnt 0..WAIT_CYCLES). stallreq_o=1.
//   ce_n=0 and be_n=~sel_q for the whole state. Addr and data come from the latched regs.
//   read : oe_n=0 all cycles. At cnt==WAIT_CYCLES, rdata_q<=sram_data_i. Next state is DONE.
//   write: data_oe=1 all cycles. we_n=0 while cnt<WAIT_CYCLES and we_n=1 at cnt==WAIT_CYCLES
//   (hold cycle: addr/data stable across WE rising). Next state is DONE.
//  DONE: stallreq_o=0. mem_data_o=rdata_q for reads, 0 for writes. All strobes inactive.
//   Stay in DONE while pipe_hold_i=1, with mem_data_o held. Otherwise go to IDLE.
//   A request is never re-accepted in DONE, so the still-asserted mem_ce_i is not reissued.
//  Latency: request in cycle T, stallreq_o high T..T+WAIT_CYCLES+1, DONE at T+WAIT_CYCLES+2.
//   With default parameters: 4 stall cycles, DONE at T+4.
//  Back-to-back: the new request is accepted in the IDLE cycle after DONE, with no bubble beyond that.
//  sel=4'h0 with ce=1: full access timing runs, be_n stays 4'hF, read returns sampled bus.
//  Request inputs are ignored outside IDLE. Request regs are stable for the whole access.
//  Strobe outputs are registered from next-state/cnt, so there are no glitches on SRAM pins.
// STRUCTURE
//  defines.v: add DSC_IDLE/DSC_ACCESS/DSC_DONE encodings (2-bit), reuse `RegBus.
//  Single module: FSM, wait counter, request/read-data regs. No sub-module warranted.
//  Top-level: instantiated beside mips; stallreq_o joins the pipeline stall controller.
// TESTING
//  1 Read, WAIT=2: addr=0x0000_0010, SRAM model word4=0xDEADBEEF -> stall 4 cycles, oe_n low 3
//    cycles, sram_addr=4, DONE mem_data_o=0xDEADBEEF.
//  2 Write byte: sel=4'b0010, data=0x0000AB00, addr=0x8 -> be_n=4'b1101, we_n low 2 cycles then
//    high 1 hold cycle; read-back of word2 gives only byte1=0xAB changed.
//  3 Back-to-back write then read same addr -> second access starts the cycle after DONE and
//    returns the written value. No duplicate write (count we_n falling edges = 1).
//  4 pipe_hold_i=1 for 3 cycles in DONE with ce still high -> stays DONE, mem_data_o stable,
//    no new SRAM strobe. Release -> IDLE.
//  5 rst pulsed at ACCESS cnt=1 of a write -> next edge: we_n=1, ce_n=1, data_oe=0, stallreq_o=0.
//    Next request completes normally.
//  6 Addr 0xFFFF_FFFC with ADDR_W=20 -> sram_addr=20'hFFFFF (upper bits ignored). Timing unchanged.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and helpers for the data-memory to asynchronous SRAM bridge:
// FSM encoding, latched request layout and the SRAM strobe bundle.
package data_sram_ctrl_pkg;

   localparam int REG_BUS_W = 32;
   localparam int SEL_W     = 4;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      DSC_IDLE   = 2'd0,
      DSC_ACCESS = 2'd1,
      DSC_DONE   = 2'd2
   } dsc_state_e;

   typedef struct packed {
      logic                 we;
      logic [SEL_W-1:0]     sel;
      logic [REG_BUS_W-1:0] wdata;
   } dsc_req_t;

   typedef struct packed {
      logic             ce_n;
      logic             oe_n;
      logic             we_n;
      logic [SEL_W-1:0] be_n;
      logic             data_oe;
   } sram_strobe_t;

   localparam sram_strobe_t STROBE_IDLE = '{
      ce_n:    1'b1,
      oe_n:    1'b1,
      we_n:    1'b1,
      be_n:    4'hF,
      data_oe: 1'b0
   };

   // Strobe pattern for a given (next) state and wait count. The last ACCESS
   // cycle of a write releases WE while address and data stay driven.
   function automatic sram_strobe_t strobe_for(
      input dsc_state_e       st,
      input logic [CNT_W-1:0] cnt,
      input logic [CNT_W-1:0] last,
      input logic             we,
      input logic [SEL_W-1:0] sel
   );
      sram_strobe_t s;
      s = STROBE_IDLE;
      if (st == DSC_ACCESS) begin
         s.ce_n = 1'b0;
         s.be_n = ~sel;
         if (we) begin
            s.data_oe = 1'b1;
            s.we_n    = (cnt == last) ? 1'b1 : 1'b0;
         end else begin
            s.oe_n = 1'b0;
         end
      end else begin
         s = STROBE_IDLE;
      end
      return s;
   endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// MEM-stage data port to word-wide asynchronous SRAM bridge. Latches one request,
// runs WAIT_CYCLES strobe cycles plus a sample/hold cycle, and stalls the pipeline meanwhile.
module data_sram_ctrl
   import data_sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_ce_i,
   input  logic                 mem_we_i,
   input  logic [SEL_W-1:0]     mem_sel_i,
   input  logic [REG_BUS_W-1:0] mem_addr_i,
   input  logic [REG_BUS_W-1:0] mem_data_i,
   input  logic                 pipe_hold_i,
   output logic [REG_BUS_W-1:0] mem_data_o,
   output logic                 stallreq_o,
   output logic [ADDR_W-1:0]    sram_addr_o,
   output logic [REG_BUS_W-1:0] sram_data_o,
   input  logic [REG_BUS_W-1:0] sram_data_i,
   output logic                 sram_data_oe_o,
   output logic                 sram_ce_n_o,
   output logic                 sram_oe_n_o,
   output logic                 sram_we_n_o,
   output logic [SEL_W-1:0]     sram_be_n_o
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

   dsc_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   dsc_req_t             req_q, req_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [REG_BUS_W-1:0] rdata_q, rdata_d;
   sram_strobe_t         strobe_q, strobe_d;

   // Byte-offset bits and address bits above the SRAM word range are dropped (wrap).
   if (ADDR_W + 2 < REG_BUS_W) begin : g_addr_wrap
      logic unused_addr_bits;
      assign unused_addr_bits = ^{mem_addr_i[REG_BUS_W-1:ADDR_W+2], mem_addr_i[1:0]};
   end else begin : g_addr_full
      logic unused_addr_bits;
      assign unused_addr_bits = ^mem_addr_i[1:0];
   end

   // Next-state, wait counter, request latch and read-data capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      case (state_q)
         DSC_IDLE: begin
            if (mem_ce_i) begin
               state_d     = DSC_ACCESS;
               cnt_d       = {CNT_W{1'b0}};
               req_d.we    = mem_we_i;
               req_d.sel   = mem_sel_i;
               req_d.wdata = mem_data_i;
               addr_d      = mem_addr_i[ADDR_W+1:2];
            end else begin
               state_d = DSC_IDLE;
            end
         end
         DSC_ACCESS: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = DSC_DONE;
               if (!req_q.we) begin
                  rdata_d = sram_data_i;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DSC_DONE: begin
            // The MEM stage still presents the finished request here; never re-accept it.
            if (pipe_hold_i) begin
               state_d = DSC_DONE;
            end else begin
               state_d = DSC_IDLE;
            end
         end
         default: begin
            state_d = DSC_IDLE;
         end
      endcase
      strobe_d = strobe_for(state_d, cnt_d, WAIT_LAST, req_d.we, req_d.sel);
   end

   // State, request and strobe registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DSC_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         req_q    <= '{we: 1'b0, sel: {SEL_W{1'b0}}, wdata: {REG_BUS_W{1'b0}}};
         addr_q   <= {ADDR_W{1'b0}};
         rdata_q  <= {REG_BUS_W{1'b0}};
         strobe_q <= STROBE_IDLE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         strobe_q <= strobe_d;
      end
   end

   // Stall request and MEM-stage read data, both forced quiet during reset.
   always_comb begin
      stallreq_o = 1'b0;
      mem_data_o = {REG_BUS_W{1'b0}};
      if (rst) begin
         stallreq_o = 1'b0;
         mem_data_o = {REG_BUS_W{1'b0}};
      end else begin
         case (state_q)
            DSC_IDLE:   stallreq_o = mem_ce_i;
            DSC_ACCESS: stallreq_o = 1'b1;
            DSC_DONE:   stallreq_o = 1'b0;
            default:    stallreq_o = 1'b0;
         endcase
         if ((state_q == DSC_DONE) && !req_q.we) begin
            mem_data_o = rdata_q;
         end else begin
            mem_data_o = {REG_BUS_W{1'b0}};
         end
      end
   end

   assign sram_addr_o    = addr_q;
   assign sram_data_o    = req_q.wdata;
   assign sram_data_oe_o = strobe_q.data_oe;
   assign sram_ce_n_o    = strobe_q.ce_n;
   assign sram_oe_n_o    = strobe_q.oe_n;
   assign sram_we_n_o    = strobe_q.we_n;
   assign sram_be_n_o    = strobe_q.be_n;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl with a behavioural async SRAM and a
// scoreboard queue of expected MEM-stage read data.
module tb_data_sram_ctrl;

   localparam int W  = 2;
   localparam int AW = 20;

   logic          clk;
   logic          rst;
   logic          mem_ce_i;
   logic          mem_we_i;
   logic [3:0]    mem_sel_i;
   logic [31:0]   mem_addr_i;
   logic [31:0]   mem_data_i;
   logic          pipe_hold_i;
   logic [31:0]   mem_data_o;
   logic          stallreq_o;
   logic [AW-1:0] sram_addr_o;
   logic [31:0]   sram_data_o;
   logic [31:0]   sram_data_i;
   logic          sram_data_oe_o;
   logic          sram_ce_n_o;
   logic          sram_oe_n_o;
   logic          sram_we_n_o;
   logic [3:0]    sram_be_n_o;

   int            vectors;
   int            miscompares;
   int            we_falls;
   logic          armed;
   logic [31:0]   sb[$];
   logic [31:0]   mem [0:(1<<AW)-1];

   data_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .pipe_hold_i    (pipe_hold_i),
      .mem_data_o     (mem_data_o),
      .stallreq_o     (stallreq_o),
      .sram_addr_o    (sram_addr_o),
      .sram_data_o    (sram_data_o),
      .sram_data_i    (sram_data_i),
      .sram_data_oe_o (sram_data_oe_o),
      .sram_ce_n_o    (sram_ce_n_o),
      .sram_oe_n_o    (sram_oe_n_o),
      .sram_we_n_o    (sram_we_n_o),
      .sram_be_n_o    (sram_be_n_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM read path.
   assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o] : 32'h0;

   // SRAM contents: preload, then byte-lane writes committed on the WE rising edge.
   initial begin
      mem[20'h00004] = 32'hDEADBEEF;
      mem[20'h00002] = 32'h11223344;
      mem[20'hFFFFF] = 32'h12345678;
      forever begin
         @(posedge sram_we_n_o);
         if (armed && !sram_ce_n_o && sram_data_oe_o) begin
            for (int b = 0; b < 4; b++) begin
               if (!sram_be_n_o[b]) mem[sram_addr_o][b*8 +: 8] = sram_data_o[b*8 +: 8];
            end
         end
      end
   end

   initial begin
      we_falls = 0;
      forever begin
         @(negedge sram_we_n_o);
         if (armed) we_falls = we_falls + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE and follow it to DONE; returns in the DONE cycle.
   task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic [AW-1:0] exp_addr);
      int   stall_n;
      int   oe_lo;
      int   we_lo;
      int   bad;
      logic last_we_n;
      logic [31:0] exp;
      mem_ce_i    = 1'b1;
      mem_we_i    = we;
      mem_sel_i   = sel;
      mem_addr_i  = addr;
      mem_data_i  = wdata;
      pipe_hold_i = 1'b0;
      sb.push_back(we ? 32'h0 : exp_rdata);
      #1;
      check("stall_in_request_cycle", 32'(stallreq_o), 32'h1);
      check("ce_n_idle_in_request_cycle", 32'(sram_ce_n_o), 32'h1);
      stall_n   = 1;
      oe_lo     = 0;
      we_lo     = 0;
      bad       = 0;
      last_we_n = 1'b0;
      for (int c = 0; c < 64; c++) begin
         step();
         if (!stallreq_o) break;
         stall_n = stall_n + 1;
         if (!sram_oe_n_o) oe_lo = oe_lo + 1;
         if (!sram_we_n_o) we_lo = we_lo + 1;
         last_we_n = sram_we_n_o;
         if (sram_ce_n_o !== 1'b0) bad = bad + 1;
         if (sram_be_n_o !== ~sel) bad = bad + 1;
         if (sram_addr_o !== exp_addr) bad = bad + 1;
         if (we && (sram_data_o !== wdata || sram_data_oe_o !== 1'b1)) bad = bad + 1;
         if (!we && sram_data_oe_o !== 1'b0) bad = bad + 1;
      end
      check("stall_cycles", 32'(stall_n), 32'(W + 2));
      check("oe_low_cycles", 32'(oe_lo), we ? 32'h0 : 32'(W + 1));
      check("we_low_cycles", 32'(we_lo), we ? 32'(W) : 32'h0);
      check("last_access_we_n", 32'(last_we_n), 32'h1);
      check("access_pin_errors", 32'(bad), 32'h0);
      check("done_strobes_idle",
            32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o}),
            32'({1'b1, 1'b1, 1'b1, 4'hF, 1'b0}));
      exp = sb.pop_front();
      check("done_mem_data_o", mem_data_o, exp);
   endtask

   initial begin
      int wf0;
      vectors     = 0;
      miscompares = 0;
      armed       = 1'b0;
      rst         = 1'b1;
      mem_ce_i    = 1'b1;
      mem_we_i    = 1'b0;
      mem_sel_i   = 4'hF;
      mem_addr_i  = 32'h0;
      mem_data_i  = 32'h0;
      pipe_hold_i = 1'b0;
      step();
      step();
      step();
      // Reset state, with a request pending that must not raise a stall.
      check("rst_stallreq", 32'(stallreq_o), 32'h0);
      check("rst_mem_data_o", mem_data_o, 32'h0);
      check("rst_strobes",
            32'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o}),
            32'({1'b1, 1'b1, 1'b1, 4'hF, 1'b0}));
      check("rst_sram_addr", 32'(sram_addr_o), 32'h0);
      check("rst_sram_data", sram_data_o, 32'h0);
      rst      = 1'b0;
      mem_ce_i = 1'b0;
      armed    = 1'b1;
      step();
      check("idle_no_stall", 32'(stallreq_o), 32'h0);

      // Read word 4.
      access(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 20'h00004);
      mem_ce_i = 1'b0;
      step();
      check("idle_after_read_data", mem_data_o, 32'h0);

      // Byte-lane write, then read back.
      access(1'b1, 4'b0010, 32'h0000_0008, 32'h0000AB00, 32'h0, 20'h00002);
      mem_ce_i = 1'b0;
      step();
      access(1'b0, 4'hF, 32'h0000_0008, 32'h0, 32'h1122AB44, 20'h00002);
      mem_ce_i = 1'b0;
      step();

      // Back-to-back write then read, request held high across DONE.
      wf0 = we_falls;
      access(1'b1, 4'hF, 32'h0000_0030, 32'hCAFEF00D, 32'h0, 20'h0000C);
      step();
      access(1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'hCAFEF00D, 20'h0000C);
      check("b2b_single_write", 32'(we_falls - wf0), 32'h1);

      // Hold in DONE for three cycles with the request still asserted.
      step();
      wf0 = we_falls;
      access(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 20'h00004);
      pipe_hold_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("hold_no_stall", 32'(stallreq_o), 32'h0);
         check("hold_mem_data_o", mem_data_o, 32'hDEADBEEF);
         check("hold_no_strobe", 32'({sram_ce_n_o, sram_oe_n_o}), 32'h3);
      end
      pipe_hold_i = 1'b0;
      step();
      #1;
      check("release_to_idle", 32'(stallreq_o), 32'h1);
      mem_ce_i = 1'b0;
      #1;
      check("idle_after_hold_data", mem_data_o, 32'h0);
      check("hold_no_write", 32'(we_falls - wf0), 32'h0);

      // Reset during write ACCESS cnt=1.
      step();
      mem_ce_i   = 1'b1;
      mem_we_i   = 1'b1;
      mem_sel_i  = 4'hF;
      mem_addr_i = 32'h0000_0040;
      mem_data_i = 32'h5555_AAAA;
      step();
      step();
      check("pre_rst_we_low", 32'(sram_we_n_o), 32'h0);
      rst = 1'b1;
      #1;
      check("rst_mid_stallreq", 32'(stallreq_o), 32'h0);
      step();
      check("abort_strobes",
            32'({sram_we_n_o, sram_ce_n_o, sram_data_oe_o}), 32'({1'b1, 1'b1, 1'b0}));
      check("abort_stallreq", 32'(stallreq_o), 32'h0);
      rst      = 1'b0;
      mem_ce_i = 1'b0;
      step();
      // Next request after abort; zero byte select keeps BE inactive but still samples.
      access(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 20'h00004);
      mem_ce_i = 1'b0;
      step();

      // Upper address bits ignored.
      access(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 32'h12345678, 20'hFFFFF);
      mem_ce_i = 1'b0;
      step();
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
